// File: rtl/oam_dma_controller_if.sv
// Bus bundle between the CPU datapath, the shared memory port and OAM.
// slave: the DMA controller's view; master: the surrounding datapath/memory.
interface oam_dma_controller_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 8
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [REG_WIDTH-1:0]  cpu_din;
  logic                  cpu_we;
  logic                  cpu_stall;
  logic                  dma_busy;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [REG_WIDTH-1:0]  mem_din;
  logic                  mem_we;
  logic [REG_WIDTH-1:0]  mem_dout;

  logic [7:0]            oam_addr;
  logic [REG_WIDTH-1:0]  oam_din;
  logic                  oam_we;

  modport slave (
    input  cpu_addr, cpu_din, cpu_we, mem_dout,
    output cpu_stall, dma_busy, mem_addr, mem_din, mem_we,
    output oam_addr, oam_din, oam_we
  );

  modport master (
    output cpu_addr, cpu_din, cpu_we, mem_dout,
    input  cpu_stall, dma_busy, mem_addr, mem_din, mem_we,
    input  oam_addr, oam_din, oam_we
  );
endinterface

// File: rtl/oam_dma_controller.sv
// Shares the memory port between CPU passthrough and a page-to-OAM DMA.
// Trigger write stalls the CPU for 513/514 cycles; reads land on even cycles.
module oam_dma_controller #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    REG_WIDTH    = 8,
  parameter logic [ADDR_WIDTH-1:0] TRIGGER_ADDR = 16'h4014,
  parameter int                    DMA_LEN      = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  oam_dma_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t                state_q;
  state_t                state_d;
  logic [REG_WIDTH-1:0]  page_q;
  logic [7:0]            idx_q;
  logic                  parity_q;

  logic                  trigger;
  logic                  load_page;
  logic                  step_idx;
  logic [ADDR_WIDTH-1:0] dma_addr;

  // No carry out of idx_q: a transfer never leaves its source page.
  assign dma_addr = ADDR_WIDTH'({page_q, idx_q});
  assign trigger  = bus.cpu_we && (bus.cpu_addr == TRIGGER_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      if (load_page) begin
        page_q <= bus.cpu_din;
        idx_q  <= '0;
      end else if (step_idx) begin
        idx_q  <= idx_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    load_page     = 1'b0;
    step_idx      = 1'b0;
    bus.mem_addr  = dma_addr;
    bus.mem_din   = '0;
    bus.mem_we    = 1'b0;
    bus.oam_addr  = '0;
    bus.oam_din   = '0;
    bus.oam_we    = 1'b0;
    bus.cpu_stall = 1'b1;
    bus.dma_busy  = 1'b1;

    unique case (state_q)
      IDLE: begin
        bus.cpu_stall = 1'b0;
        bus.dma_busy  = 1'b0;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_din   = bus.cpu_din;
        // Gated so reset forces the write strobe low immediately.
        bus.mem_we    = bus.cpu_we && !reset;
        if (trigger) begin
          load_page = 1'b1;
          state_d   = HALT;
        end
      end
      HALT: begin
        // parity_q==1 now means the next cycle is even, so READ can go there.
        state_d = parity_q ? READ : ALIGN;
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        state_d = WRITE;
      end
      WRITE: begin
        bus.oam_we   = 1'b1;
        bus.oam_addr = idx_q;
        bus.oam_din  = bus.mem_dout;
        step_idx     = 1'b1;
        state_d      = (idx_q == LAST_IDX) ? IDLE : READ;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: idle passthrough table plus DMA sequences.
module tb_oam_dma_controller;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;

  oam_dma_controller_if #(.ADDR_WIDTH(16), .REG_WIDTH(8)) bus ();

  oam_dma_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle parity reference: 0 during the first cycle after reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [7:0] pat(input logic [7:0] page, input int i);
    logic [7:0] b;
    b = 8'(i);
    if (page == 8'h02) return b ^ 8'h5A;
    return b ^ ~page;
  endfunction

  // Memory model: synchronous read, data valid the cycle after the address.
  always @(posedge clk) begin
    bus.mem_dout <= pat(bus.mem_addr[15:8], int'(bus.mem_addr[7:0]));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the DMA completes.
  task automatic run_dma(input logic [7:0] page, input int par, input string tag);
    int stall, pulses, bad, oob, wemis, busymis, first_ok, exp_stall;
    bit done;
    stall = 0; pulses = 0; bad = 0; oob = 0; wemis = 0; busymis = 0; first_ok = 0;
    done = 1'b0;
    while ((cyc % 2) != par) begin
      @(posedge clk); #1;
    end
    exp_stall = (par == 0) ? 513 : 514;
    bus.cpu_addr = 16'h4014; bus.cpu_din = page; bus.cpu_we = 1'b1;
    @(posedge clk); #1;
    bus.cpu_addr = 16'h0000; bus.cpu_din = 8'h00; bus.cpu_we = 1'b0;
    for (int c = 0; c < 700 && !done; c++) begin
      #1;
      if (bus.cpu_stall) begin
        stall++;
        if (bus.mem_addr[15:8] != page) oob++;
        if (bus.mem_we) wemis++;
        if (bus.dma_busy !== 1'b1) busymis++;
      end else begin
        if (bus.dma_busy !== 1'b0) busymis++;
        done = 1'b1;
      end
      if (bus.oam_we) begin
        if (pulses == 0)
          first_ok = ((cyc % 2) == 1 && bus.mem_addr == {page, 8'h00} && bus.oam_addr == 8'h00) ? 1 : 0;
        if (bus.oam_addr != 8'(pulses) || bus.oam_din != pat(page, pulses)) bad++;
        pulses++;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_stall_cycles"}, stall, exp_stall);
    chk({tag, "_oam_pulses"}, pulses, 256);
    chk({tag, "_oam_bad_addr_or_data"}, bad, 0);
    chk({tag, "_addr_outside_page"}, oob, 0);
    chk({tag, "_mem_we_during_dma"}, wemis, 0);
    chk({tag, "_busy_vs_stall"}, busymis, 0);
    chk({tag, "_first_read_even_at_page_base"}, first_ok, 1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  din;
    logic        we;
    logic [15:0] e_addr;
    logic [7:0]  e_din;
    logic        e_we;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit, post_we;
    checks = 0;
    failures = 0;

    vecs[0] = '{16'h0010, 8'hA5, 1'b1, 16'h0010, 8'hA5, 1'b1};
    vecs[1] = '{16'h4015, 8'h03, 1'b1, 16'h4015, 8'h03, 1'b1};
    vecs[2] = '{16'h4014, 8'h77, 1'b0, 16'h4014, 8'h77, 1'b0};
    vecs[3] = '{16'h1234, 8'h00, 1'b0, 16'h1234, 8'h00, 1'b0};
    vecs[4] = '{16'h4013, 8'hFF, 1'b1, 16'h4013, 8'hFF, 1'b1};
    vecs[5] = '{16'hFFFF, 8'h5A, 1'b0, 16'hFFFF, 8'h5A, 1'b0};

    reset = 1'b1;
    bus.cpu_addr = '0; bus.cpu_din = '0; bus.cpu_we = 1'b0;
    #2;
    chk("rst_cpu_stall", int'(bus.cpu_stall), 0);
    chk("rst_dma_busy", int'(bus.dma_busy), 0);
    chk("rst_oam_we", int'(bus.oam_we), 0);
    chk("rst_oam_addr", int'(bus.oam_addr), 0);
    chk("rst_oam_din", int'(bus.oam_din), 0);
    chk("rst_mem_we", int'(bus.mem_we), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle passthrough and non-trigger accesses.
    for (int i = 0; i < 6; i++) begin
      bus.cpu_addr = vecs[i].addr; bus.cpu_din = vecs[i].din; bus.cpu_we = vecs[i].we;
      #1;
      chk($sformatf("vec%0d_mem_addr", i), int'(bus.mem_addr), int'(vecs[i].e_addr));
      chk($sformatf("vec%0d_mem_din", i), int'(bus.mem_din), int'(vecs[i].e_din));
      chk($sformatf("vec%0d_mem_we", i), int'(bus.mem_we), int'(vecs[i].e_we));
      chk($sformatf("vec%0d_stall", i), int'(bus.cpu_stall), 0);
      chk($sformatf("vec%0d_oam_we", i), int'(bus.oam_we), 0);
      @(posedge clk); #1;
      bus.cpu_we = 1'b0;
      #1;
      chk($sformatf("vec%0d_no_trigger_stall", i), int'(bus.cpu_stall), 0);
      chk($sformatf("vec%0d_no_trigger_busy", i), int'(bus.dma_busy), 0);
      @(posedge clk); #1;
    end

    run_dma(8'h02, 0, "page02_513");
    run_dma(8'h02, 1, "page02_514");
    run_dma(8'hFF, 0, "pageFF_wrap");
    #1;
    chk("pageFF_idle_after", int'(bus.dma_busy), 0);
    @(posedge clk); #1;

    // Reset in the middle of a transfer, while writing index 0x40.
    while ((cyc % 2) != 0) begin
      @(posedge clk); #1;
    end
    bus.cpu_addr = 16'h4014; bus.cpu_din = 8'h02; bus.cpu_we = 1'b1;
    @(posedge clk); #1;
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_din = 8'h00;
    hit = 0;
    for (int c = 0; c < 700 && hit == 0; c++) begin
      #1;
      if (bus.oam_we && bus.oam_addr == 8'h40) hit = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("abort_reached_idx40", hit, 1);
    bus.cpu_we = 1'b1; bus.cpu_addr = 16'h1000;
    reset = 1'b1;
    #1;
    chk("abort_cpu_stall", int'(bus.cpu_stall), 0);
    chk("abort_dma_busy", int'(bus.dma_busy), 0);
    chk("abort_oam_we", int'(bus.oam_we), 0);
    chk("abort_oam_addr", int'(bus.oam_addr), 0);
    chk("abort_oam_din", int'(bus.oam_din), 0);
    chk("abort_mem_we", int'(bus.mem_we), 0);
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000;
    post_we = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      if (bus.oam_we) post_we++;
    end
    chk("abort_no_oam_we_in_reset", post_we, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_dma(8'h03, 0, "restart_page03");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oam_dma_controller.md
Name: oam_dma_controller

Overview:
Sequences the shared memory port between the CPU datapath (fetcher/decoder) and a sprite OAM DMA engine. In idle it passes CPU memory accesses straight to mem. A CPU write to the DMA trigger address stalls the CPU and copies 256 bytes from page `{data,8'h00}` into OAM, with NES-accurate 513/514-cycle timing. It sits between the fetcher address/data path and the mem instance, and drives the OAM write port.

Parameters:
ADDR_WIDTH, 16, memory address width
REG_WIDTH, 8, data width
TRIGGER_ADDR, 16'h4014, CPU write address that starts a DMA
DMA_LEN, 256, bytes per transfer; must be a power of 2 and no more than 256

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
cpu_addr  in  ADDR_WIDTH  CPU/fetcher address
cpu_din  in  REG_WIDTH  CPU write data
cpu_we  in  1  CPU write enable
mem_dout  in  REG_WIDTH  mem read data; valid the cycle after mem_addr is presented
mem_addr  out  ADDR_WIDTH  address to mem
mem_din  out  REG_WIDTH  write data to mem
mem_we  out  1  mem write enable
oam_addr  out  8  OAM write index
oam_din  out  REG_WIDTH  OAM write data
oam_we  out  1  OAM write strobe; OAM captures on the same clk edge
cpu_stall  out  1  CPU must hold and ignore bus while high
dma_busy  out  1  DMA in progress (HALT through last WRITE)

Behaviour:
- Internal state:
  - state: IDLE, HALT, ALIGN, READ, WRITE
  - page_q: REG_WIDTH bits
  - idx_q: 8 bits
  - parity_q: 1 bit; toggles every clk; 0 = even cycle
- Reset (async, immediate):
  - state=IDLE; page_q, idx_q, parity_q = 0.
  - cpu_stall=0, dma_busy=0, oam_we=0, oam_addr=0, oam_din=0, mem_we=0.
  - Reset mid-DMA aborts the transfer. OAM keeps whatever was already written.
- IDLE:
  - mem_addr=cpu_addr, mem_din=cpu_din, mem_we=cpu_we (combinational passthrough).
  - If cpu_we=1 and cpu_addr==TRIGGER_ADDR: the write still passes to mem, page_q<=cpu_din, idx_q<=0, next state HALT.
  - Other addresses, including TRIGGER_ADDR reads, do not trigger.
- HALT (1 cycle):
  - cpu_stall=1, dma_busy=1, mem_we=0.
  - Next state is READ if the next cycle is even (parity_q==1 now), else ALIGN.
- ALIGN (1 cycle): stall held, mem_we=0; next state READ. Every READ therefore lands on an even cycle.
- READ:
  - mem_addr={page_q, idx_q}, mem_we=0, oam_we=0.
  - Next state WRITE.
- WRITE:
  - oam_we=1, oam_addr=idx_q, oam_din=mem_dout (combinational).
  - mem_we=0; mem_addr holds its READ value.
  - At the edge: idx_q<=idx_q+1 (8-bit wrap).
  - If idx_q==DMA_LEN-1: next state IDLE, else READ.
- Outputs during DMA:
  - cpu_stall and dma_busy are 1 in HALT, ALIGN, READ, WRITE; 0 in IDLE.
  - CPU inputs are ignored throughout; a trigger cannot occur during a DMA.
  - mem_we is never 1 outside IDLE.
- Stall length:
  - 1 + 2*DMA_LEN = 513 cycles if the trigger edge falls on an odd cycle.
  - 514 cycles if it falls on an even cycle.
- Page wrap: addresses stay within the page, {page_q, 8'h00} to {page_q, 8'hFF}; there is no carry into page_q. Page 0xFF reads 0xFF00–0xFFFF.
- oam_addr and oam_din are don't-care when oam_we=0, but are driven to 0 in all non-WRITE states.

Test Plan:
1. Idle passthrough: cpu_addr=0x0010, cpu_we=1, cpu_din=0xA5 → mem_addr=0x0010, mem_we=1, mem_din=0xA5 the same cycle; cpu_stall=0.
2. Page 0x02, trigger on an odd cycle, mem[0x0200+i]=i^0x5A → cpu_stall high exactly 513 cycles; 256 oam_we pulses with oam_addr=i, oam_din=i^0x5A; returns to IDLE.
3. Same trigger one cycle later (even) → ALIGN visited; stall exactly 514 cycles; first READ addr 0x0200 on an even cycle.
4. CPU write 0x03 to 0x4015, then read of 0x4014 → no stall, no oam_we.
5. Page 0xFF → reads 0xFF00..0xFFFF, no access to 0x0000; idx wraps to 0; state ends IDLE.
6. Assert reset during WRITE at idx 0x40 → all outputs 0 immediately, no further oam_we. A new trigger with page 0x03 restarts at oam_addr 0, mem_addr 0x0300.
